pipelined_adder: RTL and testbench

//   Parametrised, pipelined ripple-chunk adder, WIDTH bits in STAGES register stages.

---
 rtl/pipelined_adder.sv | 164 ++++++++++++++++
 tb/tb_pipelined_adder.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder.sv
// Pipelined chunked adder: STAGES register stages, each adding one WIDTH/STAGES-bit chunk,
// with a single global valid/ready enable. Define SUB_EN to add the Sub input and Ovf output.
module pipelined_adder #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
`ifdef SUB_EN
  input  logic             Sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout
`ifdef SUB_EN
  ,
  output logic             Ovf
`endif
);

  localparam int CW = WIDTH / STAGES;

  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  a_d [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  b_d [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic [WIDTH-1:0]  s_d [STAGES];
  logic [STAGES-1:0] c_q;
  logic [STAGES-1:0] c_d;
  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] v_d;
  logic              ovf_q;
  logic              ovf_d;

  logic [WIDTH-1:0]  src_a [STAGES];
  logic [WIDTH-1:0]  src_b [STAGES];
  logic [WIDTH-1:0]  src_s [STAGES];
  logic [STAGES-1:0] src_c;
  logic [STAGES-1:0] src_v;
  logic [CW-1:0]     ca_s;
  logic [CW-1:0]     cb_s;
  logic [CW:0]       csum_s;

  logic              en_s;
  logic [WIDTH-1:0]  a_eff_s;
  logic [WIDTH-1:0]  b_eff_s;
  logic              c_eff_s;
  logic              unused_s;

  assign en_s     = !v_q[STAGES-1] || out_ready;
  assign in_ready = en_s;

  // Subtract folds into the operands at entry: B' = ~B, c0 = ~Cin
  always_comb begin
    a_eff_s = A;
`ifdef SUB_EN
    if (Sub) begin
      b_eff_s = ~B;
      c_eff_s = ~Cin;
    end else begin
      b_eff_s = B;
      c_eff_s = Cin;
    end
`else
    b_eff_s = B;
    c_eff_s = Cin;
`endif
  end

  // Stage i adds chunk i of its operands plus the carry registered by stage i-1
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    s_d    = s_q;
    c_d    = c_q;
    v_d    = v_q;
    ovf_d  = ovf_q;
    ca_s   = {CW{1'b0}};
    cb_s   = {CW{1'b0}};
    csum_s = {(CW+1){1'b0}};

    src_a[0] = a_eff_s;
    src_b[0] = b_eff_s;
    src_s[0] = {WIDTH{1'b0}};
    src_c[0] = c_eff_s;
    src_v[0] = in_valid;
    for (int i = 1; i < STAGES; i++) begin
      src_a[i] = a_q[i-1];
      src_b[i] = b_q[i-1];
      src_s[i] = s_q[i-1];
      src_c[i] = c_q[i-1];
      src_v[i] = v_q[i-1];
    end

    for (int i = 0; i < STAGES; i++) begin
      ca_s   = src_a[i][i*CW +: CW];
      cb_s   = src_b[i][i*CW +: CW];
      csum_s = {1'b0, ca_s} + {1'b0, cb_s} + {{CW{1'b0}}, src_c[i]};
      if (en_s) begin
        a_d[i]             = src_a[i];
        b_d[i]             = src_b[i];
        s_d[i]             = src_s[i];
        s_d[i][i*CW +: CW] = csum_s[CW-1:0];
        c_d[i]             = csum_s[CW];
        v_d[i]             = src_v[i];
`ifdef SUB_EN
        // Carry into the MSB is recovered from the sum bit: c_msb = s ^ a ^ b
        if (i == STAGES - 1) begin
          ovf_d = csum_s[CW] ^ (csum_s[CW-1] ^ ca_s[CW-1] ^ cb_s[CW-1]);
        end else begin
          ovf_d = ovf_q;
        end
`endif
      end else begin
        a_d[i] = a_q[i];
        b_d[i] = b_q[i];
        s_d[i] = s_q[i];
        c_d[i] = c_q[i];
        v_d[i] = v_q[i];
      end
    end
  end

  // Pipeline registers; every stage shifts together on en and holds otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        a_q[i] <= {WIDTH{1'b0}};
        b_q[i] <= {WIDTH{1'b0}};
        s_q[i] <= {WIDTH{1'b0}};
      end
      c_q   <= {STAGES{1'b0}};
      v_q   <= {STAGES{1'b0}};
      ovf_q <= 1'b0;
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        a_q[i] <= a_d[i];
        b_q[i] <= b_d[i];
        s_q[i] <= s_d[i];
      end
      c_q   <= c_d;
      v_q   <= v_d;
      ovf_q <= ovf_d;
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign S         = s_q[STAGES-1];
  assign Cout      = c_q[STAGES-1];
`ifdef SUB_EN
  assign Ovf       = ovf_q;
  assign unused_s  = ^{a_q[STAGES-1], b_q[STAGES-1]};
`else
  assign unused_s  = ^{a_q[STAGES-1], b_q[STAGES-1], ovf_q};
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench for pipelined_adder (WIDTH=64, STAGES=4); subtract vectors run when SUB_EN is defined.
module tb_pipelined_adder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] A;
  logic [63:0] B;
  logic        Cin;
  logic        Sub;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] S;
  logic        Cout;
  logic        Ovf;

  int errors = 0;
  int checks = 0;

  pipelined_adder #(.WIDTH(64), .STAGES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
`ifdef SUB_EN
    .Sub       (Sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (S),
    .Cout      (Cout)
`ifdef SUB_EN
    ,
    .Ovf       (Ovf)
`endif
  );

`ifndef SUB_EN
  assign Ovf = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [64:0] model(input logic [63:0] a, input logic [63:0] b, input logic c);
    return {1'b0, a} + {1'b0, b} + {64'd0, c};
  endfunction

  function automatic logic [63:0] vec_a(input int k);
    return 64'hFFFF_FFFF_FFFF_FFF8 + 64'(k);
  endfunction

  function automatic logic [63:0] vec_b(input int k);
    return 64'(k) * 64'h0001_0001_0001_0001;
  endfunction

  task automatic run_single(input string tag, input logic [63:0] a, input logic [63:0] b,
                            input logic cin, input logic sub, input logic [63:0] es,
                            input logic ec, input logic eo);
    A = a; B = b; Cin = cin; Sub = sub;
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check({tag, "_lat3"}, {64'd0, out_valid}, {64'd0, 1'b0});
    tick();
    check({tag, "_lat4"}, {64'd0, out_valid}, {64'd0, 1'b1});
    check({tag, "_S"}, {1'b0, S}, {1'b0, es});
    check({tag, "_Cout"}, {64'd0, Cout}, {64'd0, ec});
`ifdef SUB_EN
    check({tag, "_Ovf"}, {64'd0, Ovf}, {64'd0, eo});
`else
    if (eo === 1'bx) $display("note: unexpected x in ovf expectation");
`endif
    tick();
  endtask

  initial begin
    logic [64:0] expq[$];
    logic [64:0] held;
    logic        stall_prev;
    logic        ov;
    logic        ir;
    int          sent;
    int          rcvd;

    rst_n = 1'b0; in_valid = 1'b0; A = 64'd0; B = 64'd0; Cin = 1'b0; Sub = 1'b0;
    out_ready = 1'b1;
    #7;
    check("rst_out_valid", {64'd0, out_valid}, {64'd0, 1'b0});
    check("rst_S", {1'b0, S}, 65'd0);
    check("rst_Cout", {64'd0, Cout}, {64'd0, 1'b0});
    check("rst_in_ready", {64'd0, in_ready}, {64'd0, 1'b1});
    #5;
    rst_n = 1'b1;
    tick();

    run_single("single", 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
               64'h0000_0001_0000_0000, 1'b0, 1'b0);
    run_single("ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, 64'd0, 1'b1, 1'b0);
    run_single("wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0);
    run_single("msb", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0,
               64'd0, 1'b1, 1'b0);
    run_single("mixed", 64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b1, 1'b0,
               64'h0001_0000_0001_0001, 1'b0, 1'b0);
`ifdef SUB_EN
    run_single("sub_ovf", 64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1,
               64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
    run_single("sub_neg", 64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    Sub = 1'b0;
`endif

    // Back-to-back: op j emerges right after edge j+4
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      in_valid = (cyc < 8);
      A = vec_a(cyc); B = vec_b(cyc); Cin = cyc[0];
      check("b2b_in_ready", {64'd0, in_ready}, {64'd0, 1'b1});
      tick();
      if (cyc >= 3 && cyc < 11) begin
        check("b2b_valid", {64'd0, out_valid}, {64'd0, 1'b1});
        check("b2b_result", {Cout, S}, model(vec_a(cyc - 3), vec_b(cyc - 3), 1'(cyc - 3)));
      end
    end
    in_valid = 1'b0;
    tick();
    check("b2b_drained", {64'd0, out_valid}, {64'd0, 1'b0});

    // Backpressure: 10 ops, out_ready low for cycles 6..10
    sent = 0; rcvd = 0; stall_prev = 1'b0; held = 65'd0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      out_ready = !(cyc >= 6 && cyc < 11);
      in_valid  = (sent < 10);
      A = vec_a(sent + 20); B = vec_b(sent + 3); Cin = sent[0];
      #1;
      ov = out_valid; ir = in_ready;
      if (ov && !out_ready) begin
        check("bp_in_ready", {64'd0, ir}, {64'd0, 1'b0});
        if (stall_prev) check("bp_S_stable", {Cout, S}, held);
        held = {Cout, S};
        stall_prev = 1'b1;
      end else begin
        stall_prev = 1'b0;
      end
      if (ov && out_ready) begin
        if (expq.size() == 0) begin
          check("bp_extra_result", {Cout, S}, 65'h1_FFFF_FFFF_FFFF_FFFF ^ {Cout, S});
        end else begin
          check("bp_result", {Cout, S}, expq.pop_front());
        end
        rcvd++;
      end
      if (in_valid && ir) begin
        expq.push_back(model(A, B, Cin));
        sent++;
      end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("bp_count", 65'(rcvd), 65'd10);
    check("bp_queue_empty", 65'(expq.size()), 65'd0);

    // Reset mid-flight with ops in the pipe
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; A = vec_a(k + 7); B = vec_b(k); Cin = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    check("mid_valid_before", {64'd0, out_valid}, {64'd0, 1'b1});
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {64'd0, out_valid}, {64'd0, 1'b0});
    check("mid_rst_S", {1'b0, S}, 65'd0);
    #1;
    rst_n = 1'b1;
    tick();
    check("mid_no_ghost", {64'd0, out_valid}, {64'd0, 1'b0});
    run_single("post_rst", 64'd2, 64'd3, 1'b0, 1'b0, 64'd5, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
